// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds PC, fetches one word per step over req/ready, presents op/funct.
// Optional FETCH_STATS_EN adds fetch_count/stall_count outputs; default build omits them.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic        retire,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic        instr_valid
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_w;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  assign pcplus4_w  = pc_q + 32'd4;
  assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Jump outranks branch; all arithmetic wraps at 32 bits.
  always_comb begin
    next_pc = pcplus4_w;
    if (jump) begin
      next_pc = {pcplus4_w[31:28], instr_q[25:0], 2'b00};
    end else if (pcsrc) begin
      next_pc = pcplus4_w + branch_off;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (retire) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Outputs decode straight from registers, so reset drops imem_req without a clock.
  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pcplus4     = pcplus4_w;
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign instr_valid = (state_q == HOLD);

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else if (state_q == FETCH) begin
      if (imem_ready) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      else            stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected fetch addresses are queued when a retire is driven
// and popped when the unit raises imem_req.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcsrc, jump, retire;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [31:0] pc, pcplus4;
  logic        instr_valid;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count, stall_count;
`endif

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .pcsrc(pcsrc), .jump(jump), .retire(retire),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr(instr), .op(op), .funct(funct),
    .pc(pc), .pcplus4(pcplus4), .instr_valid(instr_valid)
`ifdef FETCH_STATS_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int exp_fetch  = 0;
  int exp_stall  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request, compare against the scoreboard, then serve it.
  task automatic do_fetch(input logic [31:0] word, input int waits);
    logic [31:0] a;
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'd0, imem_req}, 32'd1);
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
      a = 32'hxxxx_xxxx;
    end else begin
      a = exp_q.pop_front();
    end
    check("fetch_addr", imem_addr, a);
    check("fetch_pc", pc, a);
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      @(negedge clk);
      exp_stall++;
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_addr_stable", imem_addr, a);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    exp_fetch++;
    check("accept_valid", {31'd0, instr_valid}, 32'd1);
    check("accept_req_low", {31'd0, imem_req}, 32'd0);
    check("accept_instr", instr, word);
    check("accept_op", {26'd0, op}, {26'd0, word[31:26]});
    check("accept_funct", {26'd0, funct}, {26'd0, word[5:0]});
    check("accept_pcplus4", pcplus4, a + 32'd4);
  endtask

  task automatic do_retire(input logic br, input logic jp, input logic [31:0] nxt);
    exp_q.push_back(nxt);
    retire = 1'b1;
    pcsrc  = br;
    jump   = jp;
    @(negedge clk);
    retire = 1'b0;
    pcsrc  = 1'b0;
    jump   = 1'b0;
    check("retire_valid_low", {31'd0, instr_valid}, 32'd0);
    check("retire_req_high", {31'd0, imem_req}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; pcsrc = 1'b0; jump = 1'b0; retire = 1'b0;
    imem_ready = 1'b0; imem_rdata = 32'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_pcplus4", pcplus4, 32'h4);
    check("rst_instr", instr, 32'h0);
    check("rst_op", {26'd0, op}, 32'd0);
    check("rst_funct", {26'd0, funct}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);

    reset = 1'b0;
    exp_q.push_back(32'h0);
    #1 check("idle_req_low", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    check("first_req", {31'd0, imem_req}, 32'd1);

    // Held instruction ignores retire-free cycles, controller inputs and stray ready.
    do_fetch(32'h2008_0001, 0);
    for (int i = 0; i < 3; i++) begin
      pcsrc = 1'b1; jump = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_instr", instr, 32'h2008_0001);
      check("hold_pc", pc, 32'h0);
    end
    pcsrc = 1'b0; jump = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0;

    // Sequential run 0,4,8,12,16 at two cycles per instruction.
    do_retire(1'b0, 1'b0, 32'h4);
    do_fetch(32'h0000_0020, 0);
    do_retire(1'b0, 1'b0, 32'h8);
    do_fetch(32'h0000_0021, 0);
    do_retire(1'b0, 1'b0, 32'hC);
    do_fetch(32'h0000_0022, 0);
    do_retire(1'b0, 1'b0, 32'h10);

    // Backward branch from 0x10 lands on 0x0C.
    do_fetch(32'h1000_FFFE, 0);
    do_retire(1'b1, 1'b0, 32'hC);
    do_fetch(32'h0800_0008, 0);
    do_retire(1'b0, 1'b1, 32'h20);

    // Jump wins over branch.
    do_fetch(32'h0800_0040, 0);
    do_retire(1'b1, 1'b1, 32'h100);

    // Forward branch 0x104 + 0x80.
    do_fetch(32'h1000_0020, 0);
    do_retire(1'b1, 1'b0, 32'h184);

    // Reset mid-FETCH abandons the request; ready during reset is not captured.
    check("pre_reset_addr", imem_addr, exp_q.pop_front());
    reset = 1'b1;
    #1;
    check("midreset_req", {31'd0, imem_req}, 32'd0);
    check("midreset_pc", pc, 32'h0);
    exp_fetch = 0;
    exp_stall = 0;
    imem_ready = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("midreset_instr", instr, 32'h0);
    check("midreset_valid", {31'd0, instr_valid}, 32'd0);
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    reset = 1'b0;
    exp_q.push_back(32'h0);
    #1 check("post_reset_idle", {31'd0, imem_req}, 32'd0);

    // Three wait states, then branch to 0xFFFFFFFC and wrap to 0.
    do_fetch(32'h1000_FFFE, 3);
    do_retire(1'b1, 1'b0, 32'hFFFF_FFFC);
    do_fetch(32'h0000_0024, 0);
    check("wrap_pcplus4", pcplus4, 32'h0);
    do_retire(1'b0, 1'b0, 32'h0);
    do_fetch(32'h0000_0025, 0);

`ifdef FETCH_STATS_EN
    check("fetch_count", fetch_count, exp_fetch);
    check("stall_count", stall_count, exp_stall);
`endif
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the MIPS core, directly upstream of the main controller. Holds the program counter, fetches one instruction word per step from instruction memory over a req/ready handshake, and presents `op`/`funct` to the controller. Consumes the controller's `pcsrc` and `jump` decisions on retirement to select the next PC.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pcsrc`  in  1  branch taken (from controller); sampled only on retire.
- `jump`  in  1  jump (from controller); sampled only on retire.
- `retire`  in  1  datapath has finished the held instruction.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; always equals `pc`.
- `imem_ready`  in  1  `imem_rdata` valid this cycle; completes the request.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  held instruction register.
- `op`  out  6  `instr[31:26]`.
- `funct`  out  6  `instr[5:0]`.
- `pc`  out  32  address of the held/pending instruction.
- `pcplus4`  out  32  `pc + 4`, modulo 2^32.
- `instr_valid`  out  1  `instr` is valid and awaiting retire.

## Operation
- FSM states: IDLE, FETCH, HOLD. Reset state is IDLE.
- IDLE: `imem_req`=0. Next state is FETCH unconditionally, so IDLE lasts one cycle after reset release.
- FETCH: `imem_req`=1, and `imem_addr`=`pc` is held stable. On an edge with `imem_ready`=1, `instr` <= `imem_rdata` and the FSM moves to HOLD. Otherwise it stays in FETCH.
- HOLD: `instr_valid`=1 and `imem_req`=0. On an edge with `retire`=1, `pc` <= next_pc and the FSM moves to FETCH. Otherwise `instr` and `pc` hold.
- next_pc selection, priority order:
  - `jump` selects {`pcplus4[31:28]`, `instr[25:0]`, 2'b00}.
  - else `pcsrc` selects `pcplus4` + (sign-extended `instr[15:0]` << 2).
  - else `pcplus4`.
- All address arithmetic is 32-bit and wraps modulo 2^32, with no overflow flag. For example, PC 32'hFFFF_FFFC sequences to 32'h0000_0000.
- `retire` outside HOLD is ignored. `imem_ready` outside FETCH is ignored.
- `pcsrc` and `jump` are don't-care except on a retiring edge.
- Reset asserted in any state, including mid-FETCH, takes effect immediately:
  - the request is abandoned and `imem_req` drops without waiting for a clock;
  - `pc`=`RESET_PC`;
  - a late `imem_ready` is not captured.
- Reset values: `pc`=`RESET_PC`, `pcplus4`=`RESET_PC`+4, `instr`=0, `op`=0, `funct`=0, `instr_valid`=0, `imem_req`=0, `imem_addr`=`RESET_PC`.

## Timing
- Zero-wait memory gives a minimum of 2 cycles per instruction: one FETCH cycle with `imem_ready`=1, then HOLD retired in its first cycle.
- Each memory wait cycle adds one FETCH cycle.
- `instr_valid` rises in the cycle after the accepting edge. It falls in the cycle after the retiring edge, and `imem_req` rises in that same cycle.
- `op`, `funct` and `pcplus4` are combinational from registers. No input-to-output combinational path exists except the asynchronous reset.

## Configuration
- `FETCH_STATS_EN`: when defined, adds two outputs:
  - `fetch_count` (32): increments on each accepting edge in FETCH.
  - `stall_count` (32): increments on each FETCH cycle with `imem_ready`=0.
  - Both reset to 0 and wrap modulo 2^32.
- When `FETCH_STATS_EN` is undefined, neither port nor counter exists, and fetch behaviour is identical.

## Test plan
- Reset then release, zero-wait memory, no retire: `imem_req`=0 for one cycle, then `imem_req`=1 with `imem_addr`=0. After the accept, `instr_valid`=1 and `instr` equals the returned word; the FSM holds while `retire`=0.
- Sequential run: 4 instructions retired with `pcsrc`=`jump`=0 from PC 0. Fetch addresses are 0, 4, 8, 12, each instruction taking 2 cycles.
- Taken branch: `instr`=32'h1000_FFFE at PC 32'h10, retire with `pcsrc`=1 -> next fetch at 32'h0C.
- Jump priority: `instr`=32'h0800_0040 at PC 32'h20, retire with `jump`=1 and `pcsrc`=1 -> next fetch at 32'h100.
- Wait states and reset: `imem_ready` low for 3 cycles -> `imem_addr` stable throughout and 3 extra FETCH cycles. Reset asserted mid-FETCH -> `imem_req` drops immediately and `pc`=`RESET_PC`; an `imem_ready` pulse during reset is not captured.
- Wrap and stats (`FETCH_STATS_EN` defined): retire at PC 32'hFFFF_FFFC -> next fetch at 0. After the run above, `fetch_count` equals accepted fetches and `stall_count` equals 3.
